// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that drains four input queues into one downstream queue.
// It also owns the almost-full/almost-empty thresholds that are broadcast to every queue.
module fifo_rr_arbiter #(
    parameter int DATA_SIZE       = 6,
    parameter int MAIN_QUEUE_SIZE = 4
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       init,
    input  logic [MAIN_QUEUE_SIZE-1:0] umb_almost_full_in,
    input  logic [MAIN_QUEUE_SIZE-1:0] umb_almost_empty_in,
    input  logic [3:0]                 fifo_empty,
    input  logic [4*DATA_SIZE-1:0]     data_in,
    input  logic                       out_almost_full,
    input  logic                       out_full,
    output logic [3:0]                 pop,
    output logic                       push,
    output logic [DATA_SIZE-1:0]       data_out,
    output logic [1:0]                 grant_idx,
    output logic [MAIN_QUEUE_SIZE-1:0] umb_almost_full,
    output logic [MAIN_QUEUE_SIZE-1:0] umb_almost_empty,
    output logic [2:0]                 state,
    output logic                       idle,
    output logic                       error
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 last_grant_q;
    logic [1:0]                 grant_idx_q;
    logic                       push_q, push_d;
    logic [MAIN_QUEUE_SIZE-1:0] almost_full_q;
    logic [MAIN_QUEUE_SIZE-1:0] almost_empty_q;

    logic                       err_cond;
    logic                       all_empty;
    logic                       found;
    logic [1:0]                 sel_idx;
    logic [1:0]                 cand;
    logic                       pop_en;
    logic [3:0][DATA_SIZE-1:0]  words;

    assign err_cond  = push_q & out_full;
    assign all_empty = (fifo_empty == 4'hF);
    assign words     = data_in;

    // Search starts one past the last winner so every queue gets a turn.
    // NOTE: every variable written in always_comb gets a default first; otherwise a latch is inferred.
    always_comb begin
        found   = 1'b0;
        sel_idx = last_grant_q;
        cand    = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && !fifo_empty[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // A word popped while the downstream overflows would be lost, so hold pops then.
    assign pop_en = (state_q == ST_ACTIVE) && !out_almost_full && found && !err_cond;
    assign pop    = pop_en ? (4'b0001 << sel_idx) : 4'b0000;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)            state_d = ST_INIT;
                else if (!all_empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)           state_d = ST_INIT;
                else if (all_empty) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
        if (err_cond) state_d = ST_ERROR;
        push_d = pop_en && (state_d != ST_ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q        <= ST_RESET;
            last_grant_q   <= 2'd3;
            grant_idx_q    <= 2'd0;
            push_q         <= 1'b0;
            almost_full_q  <= MAIN_QUEUE_SIZE'(6);
            almost_empty_q <= MAIN_QUEUE_SIZE'(3);
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            if (pop_en) begin
                last_grant_q <= sel_idx;
                grant_idx_q  <= sel_idx;
            end
            if (state_q == ST_INIT && init) begin
                almost_full_q  <= umb_almost_full_in;
                almost_empty_q <= umb_almost_empty_in;
            end
        end
    end

    assign push             = push_q;
    assign grant_idx        = grant_idx_q;
    assign data_out         = push_q ? words[grant_idx_q] : '0;
    assign umb_almost_full  = almost_full_q;
    assign umb_almost_empty = almost_empty_q;
    assign state            = state_q;
    assign idle             = (state_q == ST_IDLE) && !push_q;
    assign error            = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: configuration, round-robin order, backpressure,
// drain to idle, leaving ACTIVE through INIT, sticky error and reset recovery.
module tb_fifo_rr_arbiter;

    logic        clk;
    logic        reset_L;
    logic        init;
    logic [3:0]  umb_almost_full_in;
    logic [3:0]  umb_almost_empty_in;
    logic [3:0]  fifo_empty;
    logic [23:0] data_in;
    logic        out_almost_full;
    logic        out_full;
    logic [3:0]  pop;
    logic        push;
    logic [5:0]  data_out;
    logic [1:0]  grant_idx;
    logic [3:0]  umb_almost_full;
    logic [3:0]  umb_almost_empty;
    logic [2:0]  state;
    logic        idle;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [5:0] qw [4] = '{6'h0A, 6'h15, 6'h2C, 6'h33};

    fifo_rr_arbiter #(.DATA_SIZE(6), .MAIN_QUEUE_SIZE(4)) dut (
        .clk                 (clk),
        .reset_L             (reset_L),
        .init                (init),
        .umb_almost_full_in  (umb_almost_full_in),
        .umb_almost_empty_in (umb_almost_empty_in),
        .fifo_empty          (fifo_empty),
        .data_in             (data_in),
        .out_almost_full     (out_almost_full),
        .out_full            (out_full),
        .pop                 (pop),
        .push                (push),
        .data_out            (data_out),
        .grant_idx           (grant_idx),
        .umb_almost_full     (umb_almost_full),
        .umb_almost_empty    (umb_almost_empty),
        .state               (state),
        .idle                (idle),
        .error               (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".state"}, 32'(state), 32'd0);
        check({tag, ".pop"}, 32'(pop), 32'd0);
        check({tag, ".push"}, 32'(push), 32'd0);
        check({tag, ".data_out"}, 32'(data_out), 32'd0);
        check({tag, ".grant_idx"}, 32'(grant_idx), 32'd0);
        check({tag, ".idle"}, 32'(idle), 32'd0);
        check({tag, ".error"}, 32'(error), 32'd0);
        check({tag, ".almost_full"}, 32'(umb_almost_full), 32'd6);
        check({tag, ".almost_empty"}, 32'(umb_almost_empty), 32'd3);
    endtask

    initial begin
        reset_L             = 1'b0;
        init                = 1'b0;
        umb_almost_full_in  = 4'd5;
        umb_almost_empty_in = 4'd2;
        fifo_empty          = 4'hF;
        data_in             = {qw[3], qw[2], qw[1], qw[0]};
        out_almost_full     = 1'b0;
        out_full            = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_values("reset");

        // Threshold configuration: RESET -> INIT -> IDLE
        reset_L = 1'b1;
        init    = 1'b1;
        tick();
        check("cfg.state_init", 32'(state), 32'd1);
        check("cfg.af_not_yet", 32'(umb_almost_full), 32'd6);
        tick();
        tick();
        check("cfg.state_init2", 32'(state), 32'd1);
        check("cfg.af", 32'(umb_almost_full), 32'd5);
        check("cfg.ae", 32'(umb_almost_empty), 32'd2);
        init = 1'b0;
        tick();
        check("cfg.state_idle", 32'(state), 32'd2);
        check("cfg.idle", 32'(idle), 32'd1);

        // All four queues non-empty: 0,1,2,3,0
        fifo_empty = 4'h0;
        settle();
        check("rr4.no_pop_in_idle", 32'(pop), 32'd0);
        tick();
        check("rr4.state_active", 32'(state), 32'd3);
        check("rr4.no_push_first", 32'(push), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr4.pop%0d", i), 32'(pop), 32'(4'b0001 << (i % 4)));
            if (i > 0) begin
                check($sformatf("rr4.push%0d", i), 32'(push), 32'd1);
                check($sformatf("rr4.grant%0d", i), 32'(grant_idx), 32'((i - 1) % 4));
                check($sformatf("rr4.data%0d", i), 32'(data_out), 32'(qw[(i - 1) % 4]));
            end
            tick();
        end

        // Downstream almost full for three cycles
        out_almost_full = 1'b1;
        settle();
        check("af.pop0", 32'(pop), 32'd0);
        check("af.push_tail", 32'(push), 32'd1);
        check("af.data_tail", 32'(data_out), 32'(qw[0]));
        tick();
        check("af.pop1", 32'(pop), 32'd0);
        check("af.push_off", 32'(push), 32'd0);
        tick();
        check("af.pop2", 32'(pop), 32'd0);
        tick();
        out_almost_full = 1'b0;
        settle();
        check("af.resume_pop", 32'(pop), 32'd2);
        check("af.grant_held", 32'(grant_idx), 32'd0);
        tick();
        check("af.resume_push", 32'(push), 32'd1);
        check("af.resume_grant", 32'(grant_idx), 32'd1);
        check("af.resume_data", 32'(data_out), 32'(qw[1]));
        check("af.next_pop", 32'(pop), 32'd4);

        // Only queues 1 and 3 non-empty
        fifo_empty = 4'b0101;
        settle();
        check("q13.pop_a", 32'(pop), 32'd8);
        tick();
        check("q13.pop_b", 32'(pop), 32'd2);
        check("q13.grant_b", 32'(grant_idx), 32'd3);
        check("q13.data_b", 32'(data_out), 32'(qw[3]));
        tick();
        check("q13.pop_c", 32'(pop), 32'd8);
        check("q13.grant_c", 32'(grant_idx), 32'd1);
        tick();
        check("q13.pop_d", 32'(pop), 32'd2);
        check("q13.grant_d", 32'(grant_idx), 32'd3);
        tick();

        // All empty after the last pop: final push still occurs, then idle
        fifo_empty = 4'hF;
        settle();
        check("drain.pop", 32'(pop), 32'd0);
        check("drain.push", 32'(push), 32'd1);
        check("drain.grant", 32'(grant_idx), 32'd1);
        check("drain.data", 32'(data_out), 32'(qw[1]));
        check("drain.state", 32'(state), 32'd3);
        check("drain.idle_low", 32'(idle), 32'd0);
        tick();
        check("drain.state_idle", 32'(state), 32'd2);
        check("drain.idle", 32'(idle), 32'd1);
        check("drain.push_off", 32'(push), 32'd0);

        // Leave ACTIVE through INIT with a pop in flight; thresholds hold outside INIT
        umb_almost_full_in  = 4'd7;
        umb_almost_empty_in = 4'd1;
        fifo_empty          = 4'h0;
        settle();
        check("reinit.af_hold", 32'(umb_almost_full), 32'd5);
        tick();
        init = 1'b1;
        settle();
        check("reinit.pop", 32'(pop), 32'd4);
        tick();
        check("reinit.state", 32'(state), 32'd1);
        check("reinit.push", 32'(push), 32'd1);
        check("reinit.grant", 32'(grant_idx), 32'd2);
        check("reinit.data", 32'(data_out), 32'(qw[2]));
        check("reinit.no_pop", 32'(pop), 32'd0);
        tick();
        check("reinit.af", 32'(umb_almost_full), 32'd7);
        check("reinit.ae", 32'(umb_almost_empty), 32'd1);
        check("reinit.push_off", 32'(push), 32'd0);
        init       = 1'b0;
        fifo_empty = 4'hF;
        tick();
        check("reinit.idle_state", 32'(state), 32'd2);

        // Push into a full downstream queue: sticky ERROR
        fifo_empty = 4'h0;
        tick();
        check("err.pop", 32'(pop), 32'd8);
        tick();
        out_full = 1'b1;
        settle();
        check("err.push", 32'(push), 32'd1);
        check("err.error_low", 32'(error), 32'd0);
        tick();
        check("err.state", 32'(state), 32'd4);
        check("err.error", 32'(error), 32'd1);
        check("err.pop_off", 32'(pop), 32'd0);
        check("err.push_off", 32'(push), 32'd0);
        out_full = 1'b0;
        tick();
        check("err.sticky_state", 32'(state), 32'd4);
        check("err.sticky_pop", 32'(pop), 32'd0);
        check("err.sticky_push", 32'(push), 32'd0);
        reset_L = 1'b0;
        tick();
        check_reset_values("err_reset");

        // Recovery: queue 0 wins first, then reset mid-transfer drops the pending push
        reset_L = 1'b1;
        tick();
        tick();
        tick();
        check("recover.state", 32'(state), 32'd3);
        check("recover.pop", 32'(pop), 32'd1);
        reset_L = 1'b0;
        tick();
        check("midreset.push", 32'(push), 32'd0);
        check("midreset.state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
